i2c_target: RTL and testbench

//  I2C target (slave) that answers a 7-bit address and exposes an 8-bit register space through a simple

---
 rtl/i2c_defs.sv | 21 ++
 rtl/i2c_target_if.sv | 21 ++
 rtl/i2c_line_filter.sv | 50 +++++
 rtl/i2c_target.sv | 176 +++++++++++++++++
 tb/tb_i2c_target.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_defs.sv
// Shared I2C definitions: FSM state encodings and bus-level constants used by the
// target and controller blocks.
package i2c_defs;

    typedef logic [2:0] i2c_state_t;

    localparam i2c_state_t S_IDLE      = 3'd0;
    localparam i2c_state_t S_ADDR      = 3'd1;
    localparam i2c_state_t S_ADDR_ACK  = 3'd2;
    localparam i2c_state_t S_WRITE     = 3'd3;
    localparam i2c_state_t S_WRITE_ACK = 3'd4;
    localparam i2c_state_t S_READ      = 3'd5;
    localparam i2c_state_t S_READ_ACK  = 3'd6;
    localparam i2c_state_t S_IGNORE    = 3'd7;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// Pad and register-port bundle of the I2C target; slave = target side, master = pads/regfile side.
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    modport master (
        output scl_in, sda_in, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re
    );

    modport slave (
        input  scl_in, sda_in, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a level filter: a new level is taken only after
// FILTER_LEN consecutive synchronized samples agree; emits one-cycle edge strobes.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;

    // Idle bus level is high, so everything resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
                r_fall  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/i2c_target.sv
// I2C target answering TARGET_ADDR and mapping transfers onto an 8-bit register port.
// Open-drain only: SDA is pulled low or released, SCL is never stretched.
module i2c_target import i2c_defs::*; #(
    parameter logic [6:0]  TARGET_ADDR = 7'h52,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    i2c_target_if.slave  bus,
    output logic         o_busy,
    output logic         o_selected
);
    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .rst_n(rst_n), .i_line(bus.scl_in),
        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .rst_n(rst_n), .i_line(bus.sda_in),
        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    i2c_state_t r_state;
    logic [2:0] r_bit_ctr;
    logic [7:0] r_shift, r_tx, r_reg_addr, r_reg_wdata;
    logic       r_byte_done, r_first_byte, r_rw, r_ack, r_drive_load;
    logic       r_sda_oe, r_reg_we, r_reg_re, r_busy, r_selected;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_bit_ctr    <= 3'd0;
            r_shift      <= 8'h00;
            r_tx         <= 8'h00;
            r_reg_addr   <= 8'h00;
            r_reg_wdata  <= 8'h00;
            r_byte_done  <= 1'b0;
            r_first_byte <= 1'b0;
            r_rw         <= RW_WRITE;
            r_ack        <= NACK;
            r_drive_load <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_reg_we     <= 1'b0;
            r_reg_re     <= 1'b0;
            r_busy       <= 1'b0;
            r_selected   <= 1'b0;
        end else begin
            r_reg_we <= 1'b0;
            r_reg_re <= 1'b0;
            if (r_reg_we) r_reg_addr <= r_reg_addr + 8'd1;
            // reg_rdata is valid the cycle after reg_re; a re-read after a read ACK
            // also drives its MSB here since the triggering FALL has already passed.
            if (r_reg_re) begin
                if (r_drive_load) begin
                    r_sda_oe     <= ~bus.reg_rdata[7];
                    r_tx         <= {bus.reg_rdata[6:0], 1'b0};
                    r_bit_ctr    <= 3'd1;
                    r_drive_load <= 1'b0;
                end else begin
                    r_tx <= bus.reg_rdata;
                end
            end

            if (w_stop) begin
                r_state      <= S_IDLE;
                r_sda_oe     <= 1'b0;
                r_selected   <= 1'b0;
                r_busy       <= 1'b0;
                r_drive_load <= 1'b0;
            end else if (w_start) begin
                r_state      <= S_ADDR;
                r_sda_oe     <= 1'b0;
                r_selected   <= 1'b0;
                r_busy       <= 1'b1;
                r_bit_ctr    <= 3'd0;
                r_byte_done  <= 1'b0;
                r_drive_load <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    S_ADDR, S_WRITE: begin
                        r_shift   <= {r_shift[6:0], w_sda};
                        r_bit_ctr <= r_bit_ctr + 3'd1;
                        if (r_bit_ctr == 3'd7) r_byte_done <= 1'b1;
                    end
                    S_READ_ACK: r_ack <= w_sda;
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                case (r_state)
                    S_ADDR: begin
                        if (r_byte_done) begin
                            r_byte_done <= 1'b0;
                            if (r_shift[7:1] == TARGET_ADDR) begin
                                r_sda_oe   <= 1'b1;
                                r_selected <= 1'b1;
                                r_rw       <= r_shift[0];
                                r_reg_re   <= (r_shift[0] == RW_READ);
                                r_state    <= S_ADDR_ACK;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (r_rw == RW_WRITE) begin
                            r_sda_oe     <= 1'b0;
                            r_first_byte <= 1'b1;
                            r_bit_ctr    <= 3'd0;
                            r_state      <= S_WRITE;
                        end else begin
                            r_sda_oe  <= ~r_tx[7];
                            r_tx      <= {r_tx[6:0], 1'b0};
                            r_bit_ctr <= 3'd1;
                            r_state   <= S_READ;
                        end
                    end
                    S_WRITE: begin
                        if (r_byte_done) begin
                            r_byte_done <= 1'b0;
                            r_sda_oe    <= 1'b1;
                            r_state     <= S_WRITE_ACK;
                            if (r_first_byte) begin
                                r_reg_addr   <= r_shift;
                                r_first_byte <= 1'b0;
                            end else begin
                                r_reg_wdata <= r_shift;
                                r_reg_we    <= 1'b1;
                            end
                        end
                    end
                    S_WRITE_ACK: begin
                        r_sda_oe <= 1'b0;
                        r_state  <= S_WRITE;
                    end
                    S_READ: begin
                        // bit_ctr wraps to 0 once all eight bits have been driven
                        if (r_bit_ctr == 3'd0) begin
                            r_sda_oe   <= 1'b0;
                            r_reg_addr <= r_reg_addr + 8'd1;
                            r_state    <= S_READ_ACK;
                        end else begin
                            r_sda_oe  <= ~r_tx[7];
                            r_tx      <= {r_tx[6:0], 1'b0};
                            r_bit_ctr <= r_bit_ctr + 3'd1;
                        end
                    end
                    S_READ_ACK: begin
                        if (r_ack == ACK) begin
                            r_reg_re     <= 1'b1;
                            r_drive_load <= 1'b1;
                            r_state      <= S_READ;
                        end else begin
                            r_state <= S_IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_oe    = r_sda_oe;
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.reg_we    = r_reg_we;
    assign bus.reg_re    = r_reg_re;
    assign o_busy        = r_busy;
    assign o_selected    = r_selected;
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C controller on the pads and a 256x8 RAM
// behind the register port.
module tb_i2c_target;
    import i2c_defs::*;

    localparam int Q = 125;  // quarter of a 500-unit SCL period

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda_low = 1'b0;
    logic preload = 1'b1;
    logic busy, selected;
    logic sda_line;
    logic [7:0] ram [256];
    int n_vec = 0;
    int n_miss = 0;
    int cnt_we = 0, cnt_re = 0, cnt_oe = 0, cnt_both = 0;

    always #5 clk = ~clk;

    i2c_target_if bus ();

    i2c_target #(.TARGET_ADDR(7'h52), .FILTER_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .o_busy(busy), .o_selected(selected)
    );

    assign sda_line      = ~(sda_low | bus.sda_oe);
    assign bus.scl_in    = scl;
    assign bus.sda_in    = sda_line;
    assign bus.reg_rdata = ram[bus.reg_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[8'h20] <= 8'hC3;
            ram[8'h21] <= 8'h18;
            ram[8'h22] <= 8'h7E;
        end else if (bus.reg_we) begin
            ram[bus.reg_addr] <= bus.reg_wdata;
        end
        if (bus.reg_we) cnt_we <= cnt_we + 1;
        if (bus.reg_re) cnt_re <= cnt_re + 1;
        if (bus.sda_oe) cnt_oe <= cnt_oe + 1;
        if (bus.reg_we && bus.reg_re) cnt_both <= cnt_both + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input logic b, input logic glitch);
        sda_low = ~b;
        #Q scl = 1'b1;
        if (glitch) begin
            // one-clk pulses: a would-be START/STOP on SDA, then a would-be FALL/RISE on SCL
            #40 sda_low = b;
            #10 sda_low = ~b;
            #30 scl = 1'b0;
            #10 scl = 1'b1;
            #(2*Q-90);
        end else begin
            #(2*Q);
        end
        scl = 1'b0;
        #Q;
    endtask

    task automatic bit_in(output logic b);
        sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q b = sda_line;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(d[i], glitch);
        bit_in(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(ack, 1'b0);
    endtask

    task automatic start_cond();
        sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q sda_low = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic stop_cond();
        sda_low = 1'b1;
        #Q scl = 1'b1;
        #Q sda_low = 1'b0;
        #Q;
    endtask

    initial begin
        logic ack, b;
        logic [7:0] d;
        int s_we, s_re, s_oe;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        preload = 1'b0;
        #100;
        check("rst_sda_oe", 8'(bus.sda_oe), 8'd0);
        check("rst_reg_addr", bus.reg_addr, 8'h00);
        check("rst_reg_wdata", bus.reg_wdata, 8'h00);
        check("rst_reg_we", 8'(bus.reg_we), 8'd0);
        check("rst_reg_re", 8'(bus.reg_re), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_selected", 8'(selected), 8'd0);

        // 1: pointer write then two data bytes
        s_we = cnt_we;
        start_cond();
        check("t1_busy", 8'(busy), 8'd1);
        write_byte(8'hA4, 1'b0, ack); check("t1_addr_ack", 8'(ack), 8'(ACK));
        check("t1_selected", 8'(selected), 8'd1);
        write_byte(8'h10, 1'b0, ack); check("t1_ptr_ack", 8'(ack), 8'(ACK));
        write_byte(8'h5A, 1'b0, ack); check("t1_d0_ack", 8'(ack), 8'(ACK));
        write_byte(8'h6B, 1'b0, ack); check("t1_d1_ack", 8'(ack), 8'(ACK));
        stop_cond();
        check("t1_ram10", ram[8'h10], 8'h5A);
        check("t1_ram11", ram[8'h11], 8'h6B);
        check("t1_reg_addr", bus.reg_addr, 8'h12);
        check("t1_we_count", 8'(cnt_we - s_we), 8'd2);
        check("t1_busy_after", 8'(busy), 8'd0);
        check("t1_sel_after", 8'(selected), 8'd0);

        // 2: set pointer, repeated START, read three bytes
        s_re = cnt_re;
        start_cond();
        write_byte(8'hA4, 1'b0, ack); check("t2_addr_ack", 8'(ack), 8'(ACK));
        write_byte(8'h20, 1'b0, ack); check("t2_ptr_ack", 8'(ack), 8'(ACK));
        start_cond();
        write_byte(8'hA5, 1'b0, ack); check("t2_raddr_ack", 8'(ack), 8'(ACK));
        read_byte(ACK, d);  check("t2_rd0", d, 8'hC3);
        read_byte(ACK, d);  check("t2_rd1", d, 8'h18);
        read_byte(NACK, d); check("t2_rd2", d, 8'h7E);
        stop_cond();
        check("t2_reg_addr", bus.reg_addr, 8'h23);
        check("t2_re_count", 8'(cnt_re - s_re), 8'd3);
        check("t2_busy_after", 8'(busy), 8'd0);

        // 3: foreign address must leave the bus and register port untouched
        s_we = cnt_we; s_re = cnt_re; s_oe = cnt_oe;
        start_cond();
        write_byte(8'hA6, 1'b0, ack); check("t3_addr_nack", 8'(ack), 8'(NACK));
        check("t3_selected", 8'(selected), 8'd0);
        write_byte(8'h55, 1'b0, ack); check("t3_data_nack", 8'(ack), 8'(NACK));
        check("t3_oe_count", 8'(cnt_oe - s_oe), 8'd0);
        check("t3_we_count", 8'(cnt_we - s_we), 8'd0);
        check("t3_re_count", 8'(cnt_re - s_re), 8'd0);
        stop_cond();

        // 4: pointer wrap 0xFF -> 0x00
        start_cond();
        write_byte(8'hA4, 1'b0, ack); check("t4_addr_ack", 8'(ack), 8'(ACK));
        write_byte(8'hFF, 1'b0, ack);
        write_byte(8'h11, 1'b0, ack);
        write_byte(8'h22, 1'b0, ack); check("t4_d1_ack", 8'(ack), 8'(ACK));
        stop_cond();
        check("t4_ramFF", ram[8'hFF], 8'h11);
        check("t4_ram00", ram[8'h00], 8'h22);
        check("t4_reg_addr", bus.reg_addr, 8'h01);

        // 5: glitch rejection, on the idle bus and inside a data byte
        sda_low = 1'b1;
        #10 sda_low = 1'b0;
        #200;
        check("t5_idle_glitch_busy", 8'(busy), 8'd0);
        start_cond();
        write_byte(8'hA4, 1'b0, ack);
        write_byte(8'h30, 1'b0, ack);
        write_byte(8'h96, 1'b1, ack); check("t5_glitch_ack", 8'(ack), 8'(ACK));
        write_byte(8'h3C, 1'b0, ack); check("t5_after_ack", 8'(ack), 8'(ACK));
        stop_cond();
        check("t5_ram30", ram[8'h30], 8'h96);
        check("t5_ram31", ram[8'h31], 8'h3C);
        check("t5_reg_addr", bus.reg_addr, 8'h32);

        // 6: reset while driving bit 4 of a read of 0x00 (SDA held low by the target)
        start_cond();
        write_byte(8'hA4, 1'b0, ack);
        write_byte(8'h40, 1'b0, ack);
        start_cond();
        write_byte(8'hA5, 1'b0, ack); check("t6_raddr_ack", 8'(ack), 8'(ACK));
        for (int i = 0; i < 3; i++) bit_in(b);
        sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q check("t6_pre_rst_oe", 8'(bus.sda_oe), 8'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_oe", 8'(bus.sda_oe), 8'd0);
        check("t6_rst_state", 8'(dut.r_state), 8'(S_IDLE));
        check("t6_rst_addr", bus.reg_addr, 8'h00);
        check("t6_rst_busy", 8'(busy), 8'd0);
        #(4*Q) rst_n = 1'b1;
        #(4*Q);
        start_cond();
        write_byte(8'hA4, 1'b0, ack); check("t6_w_addr_ack", 8'(ack), 8'(ACK));
        write_byte(8'h50, 1'b0, ack);
        write_byte(8'h77, 1'b0, ack); check("t6_w_data_ack", 8'(ack), 8'(ACK));
        stop_cond();
        start_cond();
        write_byte(8'hA4, 1'b0, ack);
        write_byte(8'h50, 1'b0, ack);
        start_cond();
        write_byte(8'hA5, 1'b0, ack);
        read_byte(NACK, d); check("t6_readback", d, 8'h77);
        stop_cond();
        check("t6_reg_addr", bus.reg_addr, 8'h51);
        check("we_re_overlap", 8'(cnt_both), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
